// File: rtl/multi_chan_link_monitor.sv
`default_nettype none
// ============================================================================
// Module   : multi_chan_link_monitor
// Brief    : N-channel Aurora link supervisor. Per-link error/drop/retry
//            counters, timeout-driven GT reset recovery, io_* register access.
// Revision : 1.0 - initial release
// ============================================================================
module multi_chan_link_monitor #(
    parameter int NCHAN      = 4,
    parameter int CNT_W      = 16,
    parameter int UP_TIMEOUT = 50_000_000,
    parameter int RST_PULSE  = 128
) (
    input  logic               io_clk,
    input  logic               io_reset,
    input  logic               io_sel,
    input  logic               io_sync,
    input  logic [19:0]        io_addr,
    input  logic               io_rd_en,
    input  logic               io_wr_en,
    input  logic [31:0]        io_wr_data,
    output logic [31:0]        io_rd_data,
    output logic               io_rd_ack,
    input  logic [NCHAN-1:0]   channel_up,
    input  logic [NCHAN-1:0]   lane_up,
    input  logic [NCHAN-1:0]   soft_err,
    input  logic [NCHAN-1:0]   hard_err,
    input  logic [NCHAN-1:0]   frame_err,
    output logic [NCHAN-1:0]   gt_reset_req,
    output logic [3*NCHAN-1:0] loopback_set
);

    localparam int c_TMR_W = (UP_TIMEOUT > 1) ? $clog2(UP_TIMEOUT) : 1;
    localparam int c_PUL_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_MAX  = c_TMR_W'(UP_TIMEOUT - 1);
    localparam logic [c_PUL_W-1:0] c_PUL_MAX  = c_PUL_W'(RST_PULSE - 1);
    localparam logic [3:0]         c_REG_CTRL = 4'd6;

    typedef enum logic [1:0] {
        S_DOWN  = 2'd0,
        S_UP    = 2'd1,
        S_RESET = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic        w_rd_stb;
    logic        w_wr_stb;
    logic [31:0] w_chan_rd [NCHAN];
    logic [31:0] w_rd_mux;
    logic        w_unused;

    assign w_rd_stb = io_sel & io_sync & io_rd_en;
    assign w_wr_stb = io_sel & io_sync & io_wr_en;
    assign w_unused = ^{io_addr[19:8], io_wr_data[31:6]};

    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
        state_t             r_state, w_state_nx;
        logic [c_TMR_W-1:0] r_tmr, w_tmr_nx;
        logic [c_PUL_W-1:0] r_pul, w_pul_nx;
        logic               r_req;
        logic               r_auto_en;
        logic [2:0]         r_loopback;
        logic [CNT_W-1:0]   r_soft, r_hard, r_frame, r_drop, r_retry;
        logic               w_hit, w_ctrl_wr, w_force, w_clear;
        logic               w_drop_inc, w_retry_inc;
        logic [31:0]        w_reg;

        assign w_hit     = (io_addr[7:4] == 4'(gi));
        assign w_ctrl_wr = w_wr_stb & w_hit & (io_addr[3:0] == c_REG_CTRL);
        assign w_force   = w_ctrl_wr & io_wr_data[4];
        assign w_clear   = w_ctrl_wr & io_wr_data[5];

        always_comb begin
            w_state_nx  = r_state;
            w_tmr_nx    = r_tmr;
            w_pul_nx    = r_pul;
            w_drop_inc  = 1'b0;
            w_retry_inc = 1'b0;
            // A forced reset overrides every state, including a running pulse
            if (w_force) begin
                w_state_nx  = S_RESET;
                w_tmr_nx    = '0;
                w_pul_nx    = '0;
                w_retry_inc = 1'b1;
            end else begin
                case (r_state)
                    S_DOWN: begin
                        if (channel_up[gi]) begin
                            w_state_nx = S_UP;
                            w_tmr_nx   = '0;
                        end else if (r_tmr == c_TMR_MAX) begin
                            if (r_auto_en) begin
                                w_state_nx  = S_RESET;
                                w_tmr_nx    = '0;
                                w_pul_nx    = '0;
                                w_retry_inc = 1'b1;
                            end
                        end else begin
                            w_tmr_nx = r_tmr + c_TMR_W'(1);
                        end
                    end
                    S_UP: begin
                        w_tmr_nx = '0;
                        if (!channel_up[gi]) begin
                            w_state_nx = S_DOWN;
                            w_drop_inc = 1'b1;
                        end
                    end
                    S_RESET: begin
                        if (r_pul == c_PUL_MAX) begin
                            w_state_nx = S_HOLD;
                            w_pul_nx   = '0;
                        end else begin
                            w_pul_nx = r_pul + c_PUL_W'(1);
                        end
                    end
                    S_HOLD: begin
                        if (r_pul == c_PUL_MAX) begin
                            w_state_nx = S_DOWN;
                            w_pul_nx   = '0;
                            w_tmr_nx   = '0;
                        end else begin
                            w_pul_nx = r_pul + c_PUL_W'(1);
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge io_clk) begin
            if (io_reset) begin
                r_state    <= S_DOWN;
                r_tmr      <= '0;
                r_pul      <= '0;
                r_req      <= 1'b0;
                r_auto_en  <= 1'b1;
                r_loopback <= 3'b000;
                r_soft     <= '0;
                r_hard     <= '0;
                r_frame    <= '0;
                r_drop     <= '0;
                r_retry    <= '0;
            end else begin
                r_state <= w_state_nx;
                r_tmr   <= w_tmr_nx;
                r_pul   <= w_pul_nx;
                r_req   <= (w_state_nx == S_RESET);
                if (w_ctrl_wr) begin
                    r_auto_en  <= io_wr_data[0];
                    r_loopback <= io_wr_data[3:1];
                end
                if (w_clear) begin
                    r_soft  <= '0;
                    r_hard  <= '0;
                    r_frame <= '0;
                    r_drop  <= '0;
                    r_retry <= '0;
                end else begin
                    if (soft_err[gi])  r_soft  <= f_sat_inc(r_soft);
                    if (hard_err[gi])  r_hard  <= f_sat_inc(r_hard);
                    if (frame_err[gi]) r_frame <= f_sat_inc(r_frame);
                    if (w_drop_inc)    r_drop  <= f_sat_inc(r_drop);
                    if (w_retry_inc)   r_retry <= f_sat_inc(r_retry);
                end
            end
        end

        always_comb begin
            w_reg = '0;
            if (w_hit) begin
                case (io_addr[3:0])
                    4'd0:    w_reg = {26'd0, r_state, r_auto_en, lane_up[gi], channel_up[gi], r_req};
                    4'd1:    w_reg = 32'(r_soft);
                    4'd2:    w_reg = 32'(r_hard);
                    4'd3:    w_reg = 32'(r_frame);
                    4'd4:    w_reg = 32'(r_drop);
                    4'd5:    w_reg = 32'(r_retry);
                    4'd6:    w_reg = {28'd0, r_loopback, r_auto_en};
                    default: w_reg = '0;
                endcase
            end
        end

        assign w_chan_rd[gi]            = w_reg;
        assign gt_reset_req[gi]         = r_req;
        assign loopback_set[3*gi +: 3]  = r_loopback;
    end

    // Non-selected channels contribute zero, so an OR acts as the read mux
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NCHAN; i++) begin
            w_rd_mux = w_rd_mux | w_chan_rd[i];
        end
    end

    always_ff @(posedge io_clk) begin
        if (io_reset) begin
            io_rd_data <= '0;
            io_rd_ack  <= 1'b0;
        end else begin
            io_rd_ack <= w_rd_stb;
            if (w_rd_stb) begin
                io_rd_data <= w_rd_mux;
            end
        end
    end

endmodule
`default_nettype wire
